// File: rtl/sm3_pad_pkg.sv
// sm3_pad_pkg: shared types, constants and helpers for the SM3 padding engine.
//   - pad_state_e : padding FSM states
//   - PAD_BYTE    : the 0x80 end-of-message marker byte
//   - calc_wpb    : datapath words per 512-bit block
//   - calc_lenw   : datapath words occupied by the 64-bit length field
//   - byte_popcnt : number of set bits in an (up to) 8-bit byte-valid mask
package sm3_pad_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StPad1,
        StZero,
        StLen
    } pad_state_e;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    function automatic int unsigned calc_wpb(input int unsigned dw);
        return 512 / dw;
    endfunction

    function automatic int unsigned calc_lenw(input int unsigned dw);
        return 64 / dw;
    endfunction

    function automatic logic [3:0] byte_popcnt(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + 4'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sm3_pad_byte_ins.sv
// sm3_pad_byte_ins: combinational marker insertion for the last message word.
//   Valid bytes pass through, the first invalid byte becomes 0x80 and every
//   later byte is zeroed. Byte 0 sits in the MSBs; valid bits run from the MSB.
//   An all-invalid mask yields 0x80 followed by zeros.
// Ports:
//   d_i        input  INPT_DW      last message word
//   vld_byte_i input  INPT_BYTE_W  byte valids (MSB = byte 0)
//   d_o        output INPT_DW      word with marker inserted
module sm3_pad_byte_ins
    import sm3_pad_pkg::*;
#(
    parameter int unsigned INPT_DW     = 32,
    parameter int unsigned INPT_BYTE_W = INPT_DW / 8
) (
    input  logic [INPT_DW-1:0]     d_i,
    input  logic [INPT_BYTE_W-1:0] vld_byte_i,
    output logic [INPT_DW-1:0]     d_o
);

    // Leading 1 stands in for "the byte before byte 0 was valid".
    logic [INPT_BYTE_W:0] vld_ext;
    assign vld_ext = {1'b1, vld_byte_i};

    always_comb begin
        d_o = '0;
        for (int i = 0; i < INPT_BYTE_W; i++) begin
            if (vld_ext[INPT_BYTE_W-1-i]) begin
                d_o[INPT_DW-1-8*i -: 8] = d_i[INPT_DW-1-8*i -: 8];
            end else if (vld_ext[INPT_BYTE_W-i]) begin
                d_o[INPT_DW-1-8*i -: 8] = PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/sm3_pad_gen.sv
// sm3_pad_gen: SM3 message padding engine. Passes message words through, then
//   appends the 0x80 marker, zero fill and the 64-bit big-endian bit length so
//   the output is a whole number of 512-bit blocks.
// Optional build macro: SM3_PAD_CHK_EN adds pad_err_o (sticky protocol error)
//   and handshake-stability assertions.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   msg_inpt_d_i          message word, big-endian (byte 0 in MSBs)
//   msg_inpt_vld_byte_i   byte valids, contiguous from the MSB
//   msg_inpt_vld_i        input word valid
//   msg_inpt_lst_i        last word of the message
//   msg_inpt_rdy_o        engine can accept an input word
//   pad_otpt_ena_i        downstream accepts an output word
//   pad_otpt_d_o          padded word
//   pad_otpt_vld_o        output word valid
//   pad_otpt_lst_o        last word of the final padded block
//   pad_err_o             (SM3_PAD_CHK_EN only) sticky protocol error
module sm3_pad_gen
    import sm3_pad_pkg::*;
#(
    parameter int unsigned INPT_DW     = 32,
    parameter int unsigned INPT_BYTE_W = INPT_DW / 8,
    parameter int unsigned LEN_DW      = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INPT_DW-1:0]     msg_inpt_d_i,
    input  logic [INPT_BYTE_W-1:0] msg_inpt_vld_byte_i,
    input  logic                   msg_inpt_vld_i,
    input  logic                   msg_inpt_lst_i,
    output logic                   msg_inpt_rdy_o,
    input  logic                   pad_otpt_ena_i,
`ifdef SM3_PAD_CHK_EN
    output logic                   pad_err_o,
`endif
    output logic [INPT_DW-1:0]     pad_otpt_d_o,
    output logic                   pad_otpt_vld_o,
    output logic                   pad_otpt_lst_o
);

    localparam int unsigned WPB   = calc_wpb(INPT_DW);
    localparam int unsigned LENW  = calc_lenw(INPT_DW);
    localparam int unsigned CNT_W = $clog2(WPB);

    localparam logic [CNT_W-1:0]       LEN_START = CNT_W'(WPB - LENW);
    localparam logic [CNT_W-1:0]       WCNT_LAST = CNT_W'(WPB - 1);
    localparam logic [INPT_BYTE_W-1:0] FULL_VLD  = {INPT_BYTE_W{1'b1}};
    localparam logic [INPT_DW-1:0]     PAD_WORD  = {PAD_BYTE, {(INPT_DW - 8){1'b0}}};

    pad_state_e         state_q, state_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic [LEN_DW-1:0]  bit_len_q, bit_len_d;
    logic [INPT_DW-1:0] out_d_q, out_d_d;
    logic               out_vld_q, out_vld_d;
    logic               out_lst_q, out_lst_d;

    logic               load_en;
    logic               in_fire;
    logic               in_full;
    logic [CNT_W-1:0]   wcnt_inc;
    pad_state_e         after_mark;
    logic [INPT_DW-1:0] ins_word;
    logic [LEN_DW-1:0]  len_sh;
    logic [3:0]         vld_cnt;

    sm3_pad_byte_ins #(
        .INPT_DW     (INPT_DW),
        .INPT_BYTE_W (INPT_BYTE_W)
    ) u_byte_ins (
        .d_i        (msg_inpt_d_i),
        .vld_byte_i (msg_inpt_vld_byte_i),
        .d_o        (ins_word)
    );

    // Output register may take a new word when empty or draining this cycle.
    assign load_en        = !out_vld_q || pad_otpt_ena_i;
    assign msg_inpt_rdy_o = ((state_q == StIdle) || (state_q == StData)) && load_en;
    assign in_fire        = msg_inpt_vld_i && msg_inpt_rdy_o;
    assign in_full        = (msg_inpt_vld_byte_i == FULL_VLD);
    assign vld_cnt        = byte_popcnt(8'(msg_inpt_vld_byte_i));

    // WPB is a power of two, so the counter wraps at the block boundary.
    assign wcnt_inc   = wcnt_q + 1'b1;
    // After the marker word either zero-fill or go straight to the length.
    assign after_mark = (wcnt_inc == LEN_START) ? StLen : StZero;

    // Select the length slice for the current slot, high word first.
    assign len_sh = bit_len_q >> (INPT_DW * 32'(WCNT_LAST - wcnt_q));

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        bit_len_d = bit_len_q;
        out_d_d   = out_d_q;
        out_vld_d = out_vld_q;
        out_lst_d = out_lst_q;

        unique case (state_q)
            StIdle, StData: begin
                if (in_fire) begin
                    out_vld_d = 1'b1;
                    out_lst_d = 1'b0;
                    wcnt_d    = wcnt_inc;
                    bit_len_d = bit_len_q + LEN_DW'({vld_cnt, 3'b000});
                    if (!msg_inpt_lst_i) begin
                        out_d_d = msg_inpt_d_i;
                        state_d = StData;
                    end else if (in_full) begin
                        out_d_d = msg_inpt_d_i;
                        state_d = StPad1;
                    end else begin
                        out_d_d = ins_word;
                        state_d = after_mark;
                    end
                end else if (load_en) begin
                    out_vld_d = 1'b0;
                    out_lst_d = 1'b0;
                    out_d_d   = '0;
                end
            end
            StPad1: begin
                if (load_en) begin
                    out_vld_d = 1'b1;
                    out_lst_d = 1'b0;
                    out_d_d   = PAD_WORD;
                    wcnt_d    = wcnt_inc;
                    state_d   = after_mark;
                end
            end
            StZero: begin
                if (load_en) begin
                    out_vld_d = 1'b1;
                    out_lst_d = 1'b0;
                    out_d_d   = '0;
                    wcnt_d    = wcnt_inc;
                    state_d   = after_mark;
                end
            end
            StLen: begin
                if (load_en) begin
                    out_vld_d = 1'b1;
                    out_d_d   = len_sh[INPT_DW-1:0];
                    wcnt_d    = wcnt_inc;
                    out_lst_d = 1'b0;
                    if (wcnt_q == WCNT_LAST) begin
                        out_lst_d = 1'b1;
                        bit_len_d = '0;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wcnt_q    <= '0;
            bit_len_q <= '0;
            out_d_q   <= '0;
            out_vld_q <= 1'b0;
            out_lst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            bit_len_q <= bit_len_d;
            out_d_q   <= out_d_d;
            out_vld_q <= out_vld_d;
            out_lst_q <= out_lst_d;
        end
    end

    assign pad_otpt_d_o   = out_d_q;
    assign pad_otpt_vld_o = out_vld_q;
    assign pad_otpt_lst_o = out_lst_q;

`ifdef SM3_PAD_CHK_EN
    logic                   err_q, err_d;
    logic [INPT_BYTE_W-1:0] vld_inv;
    logic                   vld_contig;

    // Contiguous-from-MSB means the inverted mask is a run of low ones.
    assign vld_inv    = ~msg_inpt_vld_byte_i;
    assign vld_contig = ((vld_inv + INPT_BYTE_W'(1)) & vld_inv) == '0;

    always_comb begin
        err_d = err_q;
        if (in_fire && (msg_inpt_lst_i ? !vld_contig : !in_full)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign pad_err_o = err_q;

    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        pad_otpt_vld_o && !pad_otpt_ena_i |=>
            pad_otpt_vld_o && $stable(pad_otpt_d_o) && $stable(pad_otpt_lst_o));
`endif

endmodule

// File: tb/tb_sm3_pad_gen.sv
// Scoreboard bench for sm3_pad_gen: a 32-bit and a 64-bit instance, directed
// messages with hand-computed padded sequences.
module tb_sm3_pad_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] in_d32;
    logic [3:0]  in_vb32;
    logic        in_vld32, in_lst32, rdy32, ena32;
    logic [31:0] out_d32;
    logic        out_vld32, out_lst32;

    logic [63:0] in_d64;
    logic [7:0]  in_vb64;
    logic        in_vld64, in_lst64, rdy64, ena64;
    logic [63:0] out_d64;
    logic        out_vld64, out_lst64;
`ifdef SM3_PAD_CHK_EN
    logic        err32, err64;
`endif

    sm3_pad_gen #(.INPT_DW(32)) u_dut32 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .msg_inpt_d_i        (in_d32),
        .msg_inpt_vld_byte_i (in_vb32),
        .msg_inpt_vld_i      (in_vld32),
        .msg_inpt_lst_i      (in_lst32),
        .msg_inpt_rdy_o      (rdy32),
        .pad_otpt_ena_i      (ena32),
`ifdef SM3_PAD_CHK_EN
        .pad_err_o           (err32),
`endif
        .pad_otpt_d_o        (out_d32),
        .pad_otpt_vld_o      (out_vld32),
        .pad_otpt_lst_o      (out_lst32)
    );

    sm3_pad_gen #(.INPT_DW(64)) u_dut64 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .msg_inpt_d_i        (in_d64),
        .msg_inpt_vld_byte_i (in_vb64),
        .msg_inpt_vld_i      (in_vld64),
        .msg_inpt_lst_i      (in_lst64),
        .msg_inpt_rdy_o      (rdy64),
        .pad_otpt_ena_i      (ena64),
`ifdef SM3_PAD_CHK_EN
        .pad_err_o           (err64),
`endif
        .pad_otpt_d_o        (out_d64),
        .pad_otpt_vld_o      (out_vld64),
        .pad_otpt_lst_o      (out_lst64)
    );

    typedef struct packed {
        logic [63:0] d;
        logic        lst;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   out_cnt32 = 0;
    bit   rand_ena  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic exp32(input logic [31:0] d, input logic lst);
        q32.push_back('{d: {32'h0, d}, lst: lst});
    endtask

    task automatic zeros32(input int n);
        repeat (n) exp32(32'h0, 1'b0);
    endtask

    task automatic exp64(input logic [63:0] d, input logic lst);
        q64.push_back('{d: d, lst: lst});
    endtask

    task automatic send32(input logic [31:0] d, input logic [3:0] vb, input logic lst);
        int n;
        n        = 0;
        in_d32   = d;
        in_vb32  = vb;
        in_lst32 = lst;
        in_vld32 = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy32) break;
            n++;
            if (n > 1000) begin
                n_checks++;
                n_fail++;
                $display("FAIL send32_timeout actual=rdy_low required=rdy_high");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_vld32 = 1'b0;
        in_lst32 = 1'b0;
    endtask

    task automatic send64(input logic [63:0] d, input logic [7:0] vb, input logic lst);
        int n;
        n        = 0;
        in_d64   = d;
        in_vb64  = vb;
        in_lst64 = lst;
        in_vld64 = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy64) break;
            n++;
            if (n > 1000) begin
                n_checks++;
                n_fail++;
                $display("FAIL send64_timeout actual=rdy_low required=rdy_high");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_vld64 = 1'b0;
        in_lst64 = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (q32.size() != 0 || q64.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_drain actual=%0d/%0d_pending required=0", name,
                         q32.size(), q64.size());
                q32.delete();
                q64.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Downstream enable: always on, or 50% random when rand_ena is set.
    initial begin
        ena32 = 1'b1;
        ena64 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ena32 = rand_ena ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    // Monitors: an output transfer happens at the next posedge when vld && ena.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_vld32 && ena32) begin
                if (q32.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out32_unexpected actual=%h required=no_output", out_d32);
                end else begin
                    e = q32.pop_front();
                    chk("out32_d", {32'h0, out_d32}, e.d);
                    chk("out32_lst", {63'h0, out_lst32}, {63'h0, e.lst});
                end
                out_cnt32++;
            end
            if (rst_n && rand_ena && out_vld32 && !ena32) begin
                chk("rdy32_stalled", {63'h0, rdy32}, 64'h0);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_vld64 && ena64) begin
                if (q64.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out64_unexpected actual=%h required=no_output", out_d64);
                end else begin
                    e = q64.pop_front();
                    chk("out64_d", out_d64, e.d);
                    chk("out64_lst", {63'h0, out_lst64}, {63'h0, e.lst});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic abc32();
        exp32(32'h61626380, 1'b0);
        zeros32(14);
        exp32(32'h00000018, 1'b1);
        send32(32'h61626300, 4'b1110, 1'b1);
    endtask

    initial begin
        int base;
        rst_n    = 1'b0;
        in_d32   = '0; in_vb32 = '0; in_vld32 = 1'b0; in_lst32 = 1'b0;
        in_d64   = '0; in_vb64 = '0; in_vld64 = 1'b0; in_lst64 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld32", {63'h0, out_vld32}, 64'h0);
        chk("rst_d32", {32'h0, out_d32}, 64'h0);
        chk("rst_lst32", {63'h0, out_lst32}, 64'h0);
        chk("rst_vld64", {63'h0, out_vld64}, 64'h0);
`ifdef SM3_PAD_CHK_EN
        chk("rst_err32", {63'h0, err32}, 64'h0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_rdy32", {63'h0, rdy32}, 64'h1);

        // Case 1: "abc"
        abc32();
        wait_drain("abc32");

        // Case 2: 56 bytes -> marker at word 14, extra block
        for (int i = 0; i < 14; i++) exp32(32'hA000_0000 | 32'(i), 1'b0);
        exp32(32'h80000000, 1'b0);
        zeros32(16);
        exp32(32'h000001C0, 1'b1);
        for (int i = 0; i < 14; i++) send32(32'hA000_0000 | 32'(i), 4'hF, i == 13);
        wait_drain("msg56");

        // Case 3: 64 bytes -> whole block of data then padding block
        for (int i = 0; i < 16; i++) exp32(32'hB100_0000 | 32'(i), 1'b0);
        exp32(32'h80000000, 1'b0);
        zeros32(14);
        exp32(32'h00000200, 1'b1);
        for (int i = 0; i < 16; i++) send32(32'hB100_0000 | 32'(i), 4'hF, i == 15);
        wait_drain("msg64");

        // Case 4: "abc" on the 64-bit datapath
        exp64(64'h6162638000000000, 1'b0);
        repeat (6) exp64(64'h0, 1'b0);
        exp64(64'h18, 1'b1);
        send64(64'h6162630000000000, 8'hE0, 1'b1);
        wait_drain("abc64");

        // Case 5: random backpressure, "abc" then the empty message
        rand_ena = 1'b1;
        abc32();
        exp32(32'h80000000, 1'b0);
        zeros32(14);
        exp32(32'h00000000, 1'b1);
        send32(32'h00000000, 4'b0000, 1'b1);
        wait_drain("stall");
        rand_ena = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Case 6: reset in the middle of zero fill, then a clean "abc"
        base = out_cnt32;
        abc32();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (out_cnt32 >= base + 5) break;
        end
        chk("mid_reach5", 64'(out_cnt32 >= base + 5), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld32", {63'h0, out_vld32}, 64'h0);
        chk("mid_rst_d32", {32'h0, out_d32}, 64'h0);
        chk("mid_rst_lst32", {63'h0, out_lst32}, 64'h0);
        q32.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        abc32();
        wait_drain("after_rst");

        // Non-last word with a partial mask
        exp32(32'h11223344, 1'b0);
        send32(32'h11223344, 4'b1100, 1'b0);
        wait_drain("partial");
`ifdef SM3_PAD_CHK_EN
        chk("err_set", {63'h0, err32}, 64'h1);
`endif
        rst_n = 1'b0;
        #1;
`ifdef SM3_PAD_CHK_EN
        chk("err_clr", {63'h0, err32}, 64'h0);
`endif
        chk("end_rst_vld32", {63'h0, out_vld32}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
